// File: rtl/i2c_cmd_seq.sv
// i2c_cmd_seq: queues byte commands for i2c_core, runs them one at a time, captures RX bytes.
// Define I2C_SEQ_TIMEOUT_EN to add a watchdog on core_busy while a transaction runs.
module i2c_cmd_seq #(
    parameter int CMD_DEPTH   = 8,
    parameter int RX_DEPTH    = 8,
    parameter int START_WAIT  = 1024,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [11:0] cmd_wdata,
    input  logic        cmd_wvalid,
    output logic        cmd_wready,
    output logic [7:0]  cmd_level,
    output logic [7:0]  rx_rdata,
    output logic        rx_rvalid,
    input  logic        rx_rready,
    input  logic        clear,
    input  logic        core_busy,
    input  logic        core_error,
    input  logic [7:0]  core_rx_data,
    input  logic        core_rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        tx_stop,
    output logic        tx_write,
    output logic        tx_read,
    output logic        seq_idle,
    output logic        seq_error,
    output logic        rx_overflow,
    output logic        irq_done
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int SWW = $clog2(START_WAIT + 1);
    localparam logic [CAW:0] CMD_FULL = (CAW + 1)'(CMD_DEPTH);
    localparam logic [RAW:0] RX_FULL  = (RAW + 1)'(RX_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // CMD FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [11:0]    cmd_mem [CMD_DEPTH];
    logic [CAW-1:0] cmd_wr_q, cmd_rd_q;
    logic [CAW:0]   cmd_cnt_q, cmd_cnt_d;
    logic           cmd_push, cmd_pop, cmd_flush;
    logic [11:0]    cmd_head;

    logic           hold_start_q;
    logic [SWW-1:0] wait_q;
    logic           err_seen_q;
    logic           done_ok;

    assign cmd_head   = cmd_mem[cmd_rd_q];
    assign cmd_wready = (cmd_cnt_q != CMD_FULL);
    assign cmd_level  = 8'(cmd_cnt_q);
    assign cmd_flush  = clear || (state_d == S_ERR);
    assign cmd_push   = cmd_wvalid && cmd_wready && !cmd_flush;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYC + 1);
    logic [TOW-1:0] to_q;

    // Held at zero outside RUN, so every RUN entry starts a fresh count.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            to_q <= '0;
        end else if (state_q != S_RUN) begin
            to_q <= '0;
        end else begin
            to_q <= to_q + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

    // ------------------------------------------------------------------
    // Sequencer next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d = state_q;
        cmd_pop = 1'b0;
        done_ok = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Waiting for core_busy=0 also covers a clear issued mid-transaction.
                if ((cmd_cnt_q != '0) && !seq_error && !core_busy) begin
                    cmd_pop = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!hold_start_q) begin
                    state_d = S_DONE;
                end else if (core_busy) begin
                    state_d = S_RUN;
                end else if (wait_q == SWW'(START_WAIT - 1)) begin
                    state_d = S_ERR;
                end
            end
            S_RUN: begin
                if (!core_busy) begin
                    state_d = S_DONE;
                end
`ifdef I2C_SEQ_TIMEOUT_EN
                else if (to_q == TOW'(TIMEOUT_CYC - 1)) begin
                    state_d = S_ERR;
                end
`endif
            end
            S_DONE: begin
                if (err_seen_q || core_error) begin
                    state_d = S_ERR;
                end else begin
                    done_ok = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (clear) begin
            state_d = S_IDLE;
            cmd_pop = 1'b0;
            done_ok = 1'b0;
        end
    end

    always_comb begin
        cmd_cnt_d = cmd_cnt_q;
        if (cmd_flush) begin
            cmd_cnt_d = '0;
        end else if (cmd_push && !cmd_pop) begin
            cmd_cnt_d = cmd_cnt_q + 1'b1;
        end else if (!cmd_push && cmd_pop) begin
            cmd_cnt_d = cmd_cnt_q - 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; occupancy counters alone decide what is valid.
    always_ff @(posedge aclk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wr_q] <= cmd_wdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cmd_wr_q  <= '0;
            cmd_rd_q  <= '0;
            cmd_cnt_q <= '0;
        end else begin
            cmd_cnt_q <= cmd_cnt_d;
            if (cmd_flush) begin
                cmd_wr_q <= '0;
                cmd_rd_q <= '0;
            end else begin
                if (cmd_push) begin
                    cmd_wr_q <= cmd_wr_q + 1'b1;
                end
                if (cmd_pop) begin
                    cmd_rd_q <= cmd_rd_q + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer state, hold register and core controls
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            hold_start_q <= 1'b0;
            wait_q       <= '0;
            err_seen_q   <= 1'b0;
            tx_data      <= 8'h00;
            tx_start     <= 1'b0;
            tx_stop      <= 1'b0;
            tx_write     <= 1'b0;
            tx_read      <= 1'b0;
            seq_error    <= 1'b0;
            seq_idle     <= 1'b0;
            irq_done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            irq_done <= done_ok;
            seq_idle <= (state_d == S_IDLE) && (cmd_cnt_d == '0);

            if (clear) begin
                seq_error <= 1'b0;
            end else if (state_d == S_ERR) begin
                seq_error <= 1'b1;
            end

            if (cmd_pop) begin
                wait_q <= '0;
            end else if (state_q == S_ISSUE) begin
                wait_q <= wait_q + 1'b1;
            end

            // Error status is latched at the busy fall in case the core drops it a cycle later.
            if (cmd_pop) begin
                err_seen_q <= 1'b0;
            end else if ((state_q == S_RUN) && !core_busy) begin
                err_seen_q <= core_error;
            end

            if (clear || (state_d == S_ERR)) begin
                tx_data  <= 8'h00;
                tx_start <= 1'b0;
                tx_stop  <= 1'b0;
                tx_write <= 1'b0;
                tx_read  <= 1'b0;
            end else if (cmd_pop) begin
                hold_start_q <= cmd_head[8];
                tx_data      <= cmd_head[7:0];
                tx_start     <= cmd_head[8];
                tx_stop      <= cmd_head[9];
                tx_write     <= cmd_head[10];
                tx_read      <= cmd_head[11];
            end else if ((state_q == S_ISSUE) && (state_d != S_ISSUE)) begin
                tx_start <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX capture FIFO
    // ------------------------------------------------------------------
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wr_q, rx_rd_q;
    logic [RAW:0]   rx_cnt_q;
    logic           rx_prev_q;
    logic           rx_rise, rx_full, rx_pop, rx_push, rx_drop;

    assign rx_rise   = core_rx_valid && !rx_prev_q && !clear;
    assign rx_full   = (rx_cnt_q == RX_FULL);
    assign rx_rvalid = (rx_cnt_q != '0);
    assign rx_pop    = rx_rvalid && rx_rready && !clear;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign rx_push   = rx_rise && (!rx_full || rx_pop);
    assign rx_drop   = rx_rise && rx_full && !rx_pop;
    assign rx_rdata  = rx_rvalid ? rx_mem[rx_rd_q] : 8'h00;

    always_ff @(posedge aclk) begin
        if (rx_push) begin
            rx_mem[rx_wr_q] <= core_rx_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rx_prev_q   <= 1'b0;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            rx_cnt_q    <= '0;
            rx_overflow <= 1'b0;
        end else begin
            rx_prev_q <= core_rx_valid;
            if (clear) begin
                rx_wr_q     <= '0;
                rx_rd_q     <= '0;
                rx_cnt_q    <= '0;
                rx_overflow <= 1'b0;
            end else begin
                if (rx_push) begin
                    rx_wr_q <= rx_wr_q + 1'b1;
                end
                if (rx_pop) begin
                    rx_rd_q <= rx_rd_q + 1'b1;
                end
                if (rx_push && !rx_pop) begin
                    rx_cnt_q <= rx_cnt_q + 1'b1;
                end else if (!rx_push && rx_pop) begin
                    rx_cnt_q <= rx_cnt_q - 1'b1;
                end
                if (rx_drop) begin
                    rx_overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Self-checking bench for i2c_cmd_seq: behavioural i2c_core responder plus a command scoreboard.
module tb_i2c_cmd_seq;

    logic        aclk;
    logic        aresetn;
    logic [11:0] cmd_wdata;
    logic        cmd_wvalid;
    logic        cmd_wready;
    logic [7:0]  cmd_level;
    logic [7:0]  rx_rdata;
    logic        rx_rvalid;
    logic        rx_rready;
    logic        clear;
    logic        core_busy;
    logic        core_error;
    logic [7:0]  core_rx_data;
    logic        core_rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start, tx_stop, tx_write, tx_read;
    logic        seq_idle, seq_error, rx_overflow, irq_done;

    // Core responder drives m_*, the main thread injects RX bytes through b_*.
    logic        m_busy, m_err, m_rx_valid;
    logic [7:0]  m_rx_data;
    logic        b_rx_valid;
    logic [7:0]  b_rx_data;

    assign core_busy     = m_busy;
    assign core_error    = m_err;
    assign core_rx_valid = m_rx_valid | b_rx_valid;
    assign core_rx_data  = b_rx_valid ? b_rx_data : m_rx_data;

    int          n_total = 0;
    int          n_bad   = 0;
    int          irq_hi  = 0;
    int          start_hi = 0;
    logic        model_en;
    logic        model_err;
    int          model_len;
    logic [7:0]  rx_byte;
    logic [11:0] exp_q [$];
    logic [7:0]  rx_exp [$];

    i2c_cmd_seq dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cmd_wdata     (cmd_wdata),
        .cmd_wvalid    (cmd_wvalid),
        .cmd_wready    (cmd_wready),
        .cmd_level     (cmd_level),
        .rx_rdata      (rx_rdata),
        .rx_rvalid     (rx_rvalid),
        .rx_rready     (rx_rready),
        .clear         (clear),
        .core_busy     (core_busy),
        .core_error    (core_error),
        .core_rx_data  (core_rx_data),
        .core_rx_valid (core_rx_valid),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_stop       (tx_stop),
        .tx_write      (tx_write),
        .tx_read       (tx_read),
        .seq_idle      (seq_idle),
        .seq_error     (seq_error),
        .rx_overflow   (rx_overflow),
        .irq_done      (irq_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (irq_done) irq_hi++;
        if (tx_start) start_hi++;
    end

    // Behavioural i2c_core: acks tx_start after 3 cycles, stays busy model_len cycles.
    initial begin
        logic [11:0] e;
        m_busy = 1'b0; m_err = 1'b0; m_rx_valid = 1'b0; m_rx_data = 8'h00;
        forever begin
            @(negedge aclk);
            if (model_en && aresetn && tx_start && !m_busy) begin
                repeat (3) @(negedge aclk);
                check("start_held", 32'(tx_start), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_cmd", 32'({tx_read, tx_write, tx_stop, tx_data}),
                          32'({e[11], e[10], e[9], e[7:0]}));
                end else begin
                    check("sb_unexpected_issue", 32'(exp_q.size()), 1);
                end
                m_busy = 1'b1;
                @(negedge aclk);
                check("start_drop", 32'(tx_start), 0);
                repeat (model_len / 2) @(negedge aclk);
                if (tx_read) begin
                    m_rx_data  = rx_byte;
                    m_rx_valid = 1'b1;
                    @(negedge aclk);
                    m_rx_valid = 1'b0;
                end
                repeat (model_len / 2) @(negedge aclk);
                m_err  = model_err;
                m_busy = 1'b0;
                repeat (2) @(negedge aclk);
                m_err = 1'b0;
            end
        end
    end

    task automatic push_cmd(input logic [11:0] c, input logic expect_issue);
        @(negedge aclk);
        cmd_wdata  = c;
        cmd_wvalid = 1'b1;
        if (expect_issue) exp_q.push_back(c);
        @(negedge aclk);
        cmd_wvalid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (!(exp_q.size() == 0 && !m_busy && seq_idle) && n < lim) begin
            @(negedge aclk);
            n++;
        end
        check("idle_wait", 32'(seq_idle), 1);
    endtask

    task automatic wait_busy(input int lim);
        int n = 0;
        while (!m_busy && n < lim) begin
            @(negedge aclk);
            n++;
        end
        check("busy_wait", 32'(m_busy), 1);
    endtask

    task automatic pulse_clear();
        @(negedge aclk);
        clear = 1'b1;
        @(negedge aclk);
        clear = 1'b0;
    endtask

    // Inject one RX byte; optionally pop the head in the same cycle.
    task automatic rx_pulse(input logic [7:0] d, input logic pop);
        @(negedge aclk);
        b_rx_data  = d;
        b_rx_valid = 1'b1;
        rx_rready  = pop;
        if (pop) check("rx_pop_head", 32'(rx_rdata), 32'(rx_exp.pop_front()));
        if (rx_exp.size() < 8) rx_exp.push_back(d);
        @(negedge aclk);
        b_rx_valid = 1'b0;
        rx_rready  = 1'b0;
    endtask

    initial begin
        int irq_base;
        int start_base;
        int n;
        cmd_wdata = '0; cmd_wvalid = 1'b0; rx_rready = 1'b0; clear = 1'b0;
        b_rx_valid = 1'b0; b_rx_data = 8'h00;
        model_en = 1'b1; model_err = 1'b0; model_len = 6; rx_byte = 8'h00;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_wready", 32'(cmd_wready), 1);
        check("rst_level", 32'(cmd_level), 0);
        check("rst_idle", 32'(seq_idle), 0);
        check("rst_txs", 32'({tx_start, tx_stop, tx_write, tx_read, tx_data}), 0);
        check("rst_flags", 32'({rx_rvalid, seq_error, rx_overflow, irq_done}), 0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        check("idle_after_reset", 32'(seq_idle), 1);

        // Single write transaction.
        push_cmd(12'h7A5, 1'b1);
        wait_idle(500);
        @(negedge aclk);
        check("t1_irq", 32'(irq_hi), 1);
        check("t1_idle", 32'(seq_idle), 1);

        // Three commands queued behind a long-running one.
        model_len = 30;
        push_cmd(12'h501, 1'b1);
        wait_busy(50);
        push_cmd(12'h512, 1'b1);
        push_cmd(12'h523, 1'b1);
        push_cmd(12'h734, 1'b1);
        check("t2_level3", 32'(cmd_level), 3);
        wait_idle(1000);
        @(negedge aclk);
        check("t2_irq", 32'(irq_hi), 5);
        check("t2_level0", 32'(cmd_level), 0);
        check("t2_sb_drained", 32'(exp_q.size()), 0);

        // Read transaction returning 0x3C.
        model_len = 8;
        rx_byte   = 8'h3C;
        push_cmd(12'hBA1, 1'b1);
        wait_idle(500);
        @(negedge aclk);
        check("t3_rvalid", 32'(rx_rvalid), 1);
        check("t3_rdata", 32'(rx_rdata), 32'h3C);
        @(negedge aclk);
        rx_rready = 1'b1;
        @(negedge aclk);
        rx_rready = 1'b0;
        check("t3_empty", 32'(rx_rvalid), 0);

        // RX fill, simultaneous capture+pop on full, then overflow.
        for (int i = 0; i < 8; i++) rx_pulse(8'h10 + 8'(i), 1'b0);
        check("t4_no_ovf_full", 32'(rx_overflow), 0);
        rx_pulse(8'h20, 1'b1);
        check("t4_no_ovf_popcap", 32'(rx_overflow), 0);
        rx_pulse(8'h21, 1'b0);
        check("t4_ovf", 32'(rx_overflow), 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            check("t4_rx_byte", 32'(rx_rdata), 32'(rx_exp.pop_front()));
            rx_rready = 1'b1;
        end
        @(negedge aclk);
        rx_rready = 1'b0;
        check("t4_drained", 32'(rx_rvalid), 0);
        check("t4_ovf_sticky", 32'(rx_overflow), 1);

        // clear beats a capture in the same cycle.
        @(negedge aclk);
        b_rx_data = 8'h55; b_rx_valid = 1'b1;
        @(negedge aclk);
        b_rx_valid = 1'b0;
        check("t4_cap", 32'(rx_rvalid), 1);
        @(negedge aclk);
        b_rx_data = 8'h66; b_rx_valid = 1'b1; clear = 1'b1;
        @(negedge aclk);
        b_rx_valid = 1'b0; clear = 1'b0;
        check("t4_clear_rx", 32'(rx_rvalid), 0);
        check("t4_clear_ovf", 32'(rx_overflow), 0);

        // Core error with two commands queued.
        model_len = 20;
        model_err = 1'b1;
        push_cmd(12'h5C1, 1'b1);
        wait_busy(50);
        push_cmd(12'h5C2, 1'b0);
        push_cmd(12'h7C3, 1'b0);
        check("t5_level2", 32'(cmd_level), 2);
        irq_base = irq_hi;
        n = 0;
        while (!seq_error && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check("t5_seq_error", 32'(seq_error), 1);
        model_err = 1'b0;
        @(negedge aclk);
        check("t5_level0", 32'(cmd_level), 0);
        start_base = start_hi;
        repeat (50) @(negedge aclk);
        check("t5_no_start", 32'(start_hi - start_base), 0);
        check("t5_no_irq", 32'(irq_hi - irq_base), 0);
        check("t5_tx_zero", 32'({tx_stop, tx_write, tx_read, tx_data}), 0);
        pulse_clear();
        check("t5_err_cleared", 32'(seq_error), 0);
        check("t5_idle", 32'(seq_idle), 1);

        // clear mid-RUN: controls drop, next command waits for busy to fall.
        model_len = 30;
        push_cmd(12'h7D1, 1'b1);
        wait_busy(50);
        pulse_clear();
        check("t6_tx_zero", 32'({tx_stop, tx_write, tx_read, tx_data}), 0);
        irq_base = irq_hi;
        push_cmd(12'h7D2, 1'b1);
        start_base = start_hi;
        n = 0;
        while (m_busy && n < 100) begin
            @(negedge aclk);
            n++;
        end
        check("t6_hold_while_busy", 32'(start_hi - start_base), 0);
        wait_idle(500);
        @(negedge aclk);
        check("t6_irq", 32'(irq_hi - irq_base), 1);
        check("t6_sb_drained", 32'(exp_q.size()), 0);

        // Core never answers tx_start: error after START_WAIT cycles.
        model_en = 1'b0;
        push_cmd(12'h5E1, 1'b0);
        n = 0;
        while (!tx_start && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check("t7_start_seen", 32'(tx_start), 1);
        n = 0;
        while (!seq_error && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        check("t7_wait_cycles", 32'(n), 1024);
        check("t7_start_dropped", 32'(tx_start), 0);
        check("t7_level0", 32'(cmd_level), 0);
        pulse_clear();
        check("t7_cleared", 32'(seq_error), 0);
        model_en = 1'b1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
